// File: rtl/nibble_packer_pkg.sv
// Shared definitions for the nibble packer: state encoding, nibble width, default word size.
package nibble_packer_pkg;

    typedef enum logic {
        StFill = 1'b0,
        StHold = 1'b1
    } state_e;

    localparam int unsigned NibbleW        = 4;
    localparam int unsigned DefaultNibbles = 4;

endpackage

// File: rtl/nibble_packer.sv
// Packs 4-bit beats LSB-first into NIBBLES-wide words with early flush and a one-word output slot.
// Optional registered parity output enabled by defining NIBBLE_PACKER_PARITY_EN.
module nibble_packer
    import nibble_packer_pkg::*;
#(
    parameter int unsigned NIBBLES = DefaultNibbles,
    parameter int unsigned LEN_W   = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [NibbleW-1:0]         in_data,
    input  logic                       in_flush,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [NibbleW*NIBBLES-1:0] out_data,
    output logic [LEN_W-1:0]           out_len,
`ifdef NIBBLE_PACKER_PARITY_EN
    output logic                       out_parity,
`endif
    input  logic                       out_ready
);

    localparam int unsigned DataW = NibbleW * NIBBLES;

    state_e             state_q;
    logic [LEN_W-1:0]   cnt_q;
    logic [DataW-1:0]   coll_q;
    logic [DataW-1:0]   out_data_q;
    logic [LEN_W-1:0]   out_len_q;

    logic [DataW-1:0]   coll_d;
    logic [LEN_W-1:0]   cnt_inc;
    logic               accept;
    logic               close;

    assign in_ready = (state_q == StFill) || out_ready;
    assign accept   = in_ready && (in_valid || in_flush);

    always_comb begin
        // A fresh word starts from zero so stale upper nibbles never leak out.
        coll_d = (cnt_q == '0) ? '0 : coll_q;
        for (int unsigned k = 0; k < NIBBLES; k++) begin
            if (in_valid && (k == 32'(cnt_q))) begin
                coll_d[k*NibbleW +: NibbleW] = in_data;
            end
        end
        cnt_inc = cnt_q + {{(LEN_W-1){1'b0}}, in_valid};
        close   = (32'(cnt_inc) == NIBBLES) || (in_flush && (cnt_inc != '0));
    end

`ifdef NIBBLE_PACKER_PARITY_EN
    logic parity_q;
    assign out_parity = parity_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StFill;
            cnt_q      <= '0;
            coll_q     <= '0;
            out_data_q <= '0;
            out_len_q  <= '0;
`ifdef NIBBLE_PACKER_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else if (accept && close) begin
            state_q    <= StHold;
            cnt_q      <= '0;
            coll_q     <= '0;
            out_data_q <= coll_d;
            out_len_q  <= cnt_inc;
`ifdef NIBBLE_PACKER_PARITY_EN
            parity_q   <= ^coll_d;
`endif
        end else begin
            if (accept) begin
                cnt_q  <= cnt_inc;
                coll_q <= coll_d;
            end
            if ((state_q == StHold) && out_ready) begin
                state_q <= StFill;
            end
        end
    end

    assign out_valid = (state_q == StHold);
    assign out_data  = out_data_q;
    assign out_len   = out_len_q;

endmodule

// File: tb/tb_nibble_packer.sv
// Self-checking bench for nibble_packer: directed scenarios plus random traffic vs a queue model.
module tb_nibble_packer;

    localparam int unsigned N     = 4;
    localparam int unsigned DataW = 4 * N;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic [3:0]       in_data;
    logic             in_flush;
    logic             in_ready;
    logic             out_valid;
    logic [DataW-1:0] out_data;
    logic [2:0]       out_len;
    logic             out_ready;
`ifdef NIBBLE_PACKER_PARITY_EN
    logic             out_parity;
`endif

    nibble_packer #(
        .NIBBLES (N),
        .LEN_W   (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_flush   (in_flush),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_len    (out_len),
`ifdef NIBBLE_PACKER_PARITY_EN
        .out_parity (out_parity),
`endif
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: pending nibbles of the open word plus the single presented word.
    logic [3:0]       cur[$];
    logic             m_valid = 1'b0;
    logic [DataW-1:0] m_data  = '0;
    int unsigned      m_len   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycle(input logic rst, input logic v, input logic [3:0] d, input logic f,
                         input logic r);
        logic exp_ready;
        logic acc;
        @(negedge clk);
        reset     = rst;
        in_valid  = v;
        in_data   = d;
        in_flush  = f;
        out_ready = r;
        #1;
        exp_ready = !m_valid || r;
        if (!rst) check_eq("in_ready", 32'(in_ready), 32'(exp_ready));
        acc = !rst && exp_ready && (v || f);
        @(posedge clk);
        if (rst) begin
            cur.delete();
            m_valid = 1'b0;
            m_data  = '0;
            m_len   = 0;
        end else begin
            if (m_valid && r) m_valid = 1'b0;
            if (acc) begin
                if (v) cur.push_back(d);
                if (cur.size() == N || (f && cur.size() > 0)) begin
                    m_data = '0;
                    foreach (cur[k]) m_data = m_data | (DataW'(cur[k]) << (4 * k));
                    m_len   = cur.size();
                    m_valid = 1'b1;
                    cur.delete();
                end
            end
        end
        #1;
        check_eq("out_valid", 32'(out_valid), 32'(m_valid));
        if (rst) begin
            check_eq("rst_data", 32'(out_data), 32'h0);
            check_eq("rst_len", 32'(out_len), 32'h0);
`ifdef NIBBLE_PACKER_PARITY_EN
            check_eq("rst_parity", 32'(out_parity), 32'h0);
`endif
        end else if (m_valid) begin
            check_eq("out_data", 32'(out_data), 32'(m_data));
            check_eq("out_len", 32'(out_len), m_len);
`ifdef NIBBLE_PACKER_PARITY_EN
            check_eq("out_parity", 32'(out_parity), 32'(^m_data));
`endif
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_flush = 1'b0; out_ready = 1'b1;

        // Reset then one full word
        cycle(1, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        for (int i = 1; i <= 4; i++) cycle(0, 1, 4'(i), 0, 1);
        check_eq("w4321_valid", 32'(out_valid), 32'h1);
        check_eq("w4321_data", 32'(out_data), 32'h4321);
        check_eq("w4321_len", 32'(out_len), 32'h4);
        cycle(0, 0, 0, 0, 1);

        // Early flush, then a lone flush that must not emit
        cycle(0, 1, 4'hA, 0, 1);
        cycle(0, 1, 4'hB, 0, 1);
        cycle(0, 0, 0, 1, 1);
        check_eq("flush_data", 32'(out_data), 32'h00BA);
        check_eq("flush_len", 32'(out_len), 32'h2);
        cycle(0, 0, 0, 1, 1);
        check_eq("lone_flush", 32'(out_valid), 32'h0);
        cycle(0, 0, 0, 1, 1);
        check_eq("lone_flush2", 32'(out_valid), 32'h0);

        // Backpressure holds the word and blocks input
        for (int i = 1; i <= 4; i++) cycle(0, 1, 4'(i), 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 4'h9, 0, 0);
        check_eq("hold_ready", 32'(in_ready), 32'h0);
        check_eq("hold_data", 32'(out_data), 32'h4321);
        cycle(0, 0, 0, 0, 1);
        check_eq("hold_release", 32'(out_valid), 32'h0);

        // Continuous beats: back-to-back words
        for (int i = 1; i <= 8; i++) begin
            cycle(0, 1, 4'(i), 0, 1);
            if (i == 4) check_eq("b2b_w0", 32'(out_data), 32'h4321);
            if (i == 5) check_eq("b2b_gap", 32'(out_valid), 32'h0);
            if (i == 8) check_eq("b2b_w1", 32'(out_data), 32'h8765);
        end
        cycle(0, 0, 0, 0, 1);

        // Mid-word reset discards partial data
        cycle(0, 1, 4'h5, 0, 1);
        cycle(0, 1, 4'h6, 0, 1);
        cycle(1, 0, 0, 0, 1);
        check_eq("rst_ready", 32'(in_ready), 32'h1);
        for (int i = 1; i <= 4; i++) cycle(0, 1, 4'(i), 0, 1);
        check_eq("post_rst_data", 32'(out_data), 32'h4321);
        cycle(0, 0, 0, 0, 1);

`ifdef NIBBLE_PACKER_PARITY_EN
        cycle(0, 1, 4'h7, 1, 1);
        check_eq("par_0007_data", 32'(out_data), 32'h0007);
        check_eq("par_0007", 32'(out_parity), 32'h1);
        cycle(0, 0, 0, 0, 1);
        for (int i = 1; i <= 4; i++) cycle(0, 1, 4'(i), 0, 1);
        check_eq("par_4321", 32'(out_parity), 32'h1);
        cycle(0, 0, 0, 0, 1);
`endif

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom % 200) == 0, ($urandom % 4) != 0, 4'($urandom),
                  ($urandom % 6) == 0, ($urandom % 3) != 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/nibble_packer.md
NIBBLE_PACKER -- requirements
Module: nibble_packer

Interface
REQ-001 Parameter NIBBLES, default 4: nibbles per output word; legal range 2..8.
REQ-002 Parameter LEN_W, default 3: width of out_len; SHALL equal $clog2(NIBBLES)+1.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  upstream 4-bit logic result is present on in_data.
REQ-006 in_data  input  4  nibble produced by the upstream combinational logic stage.
REQ-007 in_flush  input  1  close the current word early; sideband of the input beat.
REQ-008 in_ready  output  1  packer can accept an input beat this cycle.
REQ-009 out_valid  output  1  out_data and out_len hold a completed word.
REQ-010 out_data  output  4*NIBBLES  packed word; unused upper nibbles are zero.
REQ-011 out_len  output  LEN_W  count of valid nibbles in out_data, 1..NIBBLES.
REQ-012 out_ready  input  1  downstream accepts the word this cycle.

Function
REQ-013 States SHALL be FILL (collecting; out_valid=0) and HOLD (word presented; out_valid=1).
REQ-014 Each output is a register; no combinational path from in_* to out_*.
REQ-015 in_ready SHALL equal (!out_valid || out_ready), i.e. the only combinational path is out_ready to in_ready.
REQ-016 An input beat is accepted when in_ready=1 and (in_valid=1 or in_flush=1).
REQ-017 Packing is LSB-first: the k-th accepted nibble (k=0..NIBBLES-1) goes to out_data[4k+3:4k].
REQ-018 An internal count cnt (0..NIBBLES-1) tracks collected nibbles; it increments per accepted in_valid beat.
REQ-019 When the accepted nibble makes NIBBLES nibbles, the next cycle SHALL be HOLD with out_len=NIBBLES, and cnt=0.
REQ-020 An accepted in_flush with cnt+in_valid > 0 SHALL close the word: the nibble (if in_valid) is included, then HOLD with out_len = cnt + in_valid.
REQ-021 An accepted in_flush with cnt=0 and in_valid=0 SHALL be a no-op; no zero-length word is ever emitted.
REQ-022 In HOLD, out_data, out_len and out_valid SHALL stay stable until out_ready=1.
REQ-023 HOLD with out_ready=1 and no accepted in_valid: next state FILL, out_valid=0.
REQ-024 HOLD with out_ready=1 and accepted in_valid: the nibble SHALL start the next word (cnt=1), with no bubble.
REQ-025 For NIBBLES=4 this gives full throughput: one word per 4 accepted beats, back-to-back.
REQ-026 Collection bits above the last valid nibble SHALL be cleared when a new word starts.

Reset
REQ-027 With reset=1 at a clock edge: state=FILL, cnt=0, out_valid=0, out_data=0, out_len=0.
REQ-028 The parity output (if present) SHALL be 0 after reset.
REQ-029 Reset SHALL take priority over all inputs.
REQ-030 A reset in mid-word or in HOLD discards the partial or held word without emitting it.
REQ-031 in_ready SHALL be 1 in the first cycle after reset is released.

Configuration
REQ-032 The feature is controlled by the macro NIBBLE_PACKER_PARITY_EN.
REQ-033 When NIBBLE_PACKER_PARITY_EN is defined, the module SHALL add output out_parity (1 bit): a register equal to the XOR of all out_data bits, valid when out_valid=1.
REQ-034 When NIBBLE_PACKER_PARITY_EN is not defined, the out_parity port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-035 The shared package SHALL hold the FILL/HOLD state encoding, the nibble width constant (4) and the default NIBBLES.
REQ-036 The block is a single module; no sub-module is natural.

Verification
REQ-037 Reset, then beats 0x1,0x2,0x3,0x4 on consecutive cycles with out_ready=1 -> out_valid=1 one cycle after the 4th beat, out_data=0x4321, out_len=4.
REQ-038 Beats 0xA,0xB, then in_flush alone -> out_data=0x00BA, out_len=2; a second lone flush with cnt=0 -> no word.
REQ-039 Word 0x4321 held with out_ready=0 for 3 cycles -> in_ready=0, outputs stable; in_valid beats are not accepted.
REQ-040 Continuous beats 0x1..0x8 with out_ready=1 -> words 0x4321 then 0x8765 with no idle cycle; the 5th beat is accepted in the release cycle.
REQ-041 Beats 0x5,0x6, reset=1 for one cycle, then beats 0x1,0x2,0x3,0x4 -> only 0x4321 is emitted; out_valid=0 directly after reset.
REQ-042 With NIBBLE_PACKER_PARITY_EN defined: word 0x0007 (in_data=0x7 plus flush) -> out_parity=1; word 0x4321 -> out_parity=1.
